// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM encodings, round constants,
// the S-box and the GF(2^8) doubling used to step Rcon.
package aes_pkg;

  localparam int AES_NR   = 10;
  localparam int RK_IDX_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] tbl;
    tbl = SBOX;
    return tbl[~{b, 3'b000} -: 8];
  endfunction

endpackage

// File: rtl/aes_key_expand_128.sv
// One combinational AES-128 key-expansion step: next round key from the
// current one and its Rcon byte.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  // SubWord(RotWord(w3)) xor Rcon in the top byte
  assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_128.sv
// Sequential AES-128 key schedule: one expansion step per cycle into an
// 11-entry round-key file with a registered indexed read port.
module aes_key_sched_128
  import aes_pkg::*;
#(
  parameter logic CLEAR_ON_LOAD = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [127:0]        key_in,
  output logic                busy,
  output logic                keys_valid,
  input  logic [RK_IDX_W-1:0] rd_idx,
  output logic [127:0]        rd_key
);

  logic [1:0]          state;
  logic [127:0]        rk [0:AES_NR];
  logic [127:0]        cur;
  logic [127:0]        nxt;
  logic [RK_IDX_W-1:0] round;
  logic [7:0]          rcon;
  logic                accept;

  // Ready depends on state only so the handshake has no combinational loop
  assign key_ready = (state != ST_EXPAND);
  assign accept    = key_valid && key_ready;

  aes_key_expand_128 u_expand (
    .key_in  (cur),
    .rcon    (rcon),
    .key_out (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      round      <= '0;
      rcon       <= RCON_INIT;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      rd_key     <= '0;
      for (int i = 0; i <= AES_NR; i++) rk[i] <= '0;
    end else begin
      // Read samples the file before this edge's write lands
      rd_key <= (rd_idx <= RK_IDX_W'(AES_NR)) ? rk[rd_idx] : '0;

      if (accept) begin
        rk[0]      <= key_in;
        cur        <= key_in;
        round      <= RK_IDX_W'(1);
        rcon       <= RCON_INIT;
        keys_valid <= 1'b0;
        busy       <= 1'b1;
        state      <= ST_EXPAND;
        if (CLEAR_ON_LOAD) begin
          for (int i = 1; i <= AES_NR; i++) rk[i] <= '0;
        end
      end else if (state == ST_EXPAND) begin
        rk[round] <= nxt;
        cur       <= nxt;
        rcon      <= xtime(rcon);
        round     <= round + RK_IDX_W'(1);
        if (round == RK_IDX_W'(AES_NR)) begin
          state      <= ST_DONE;
          busy       <= 1'b0;
          keys_valid <= 1'b1;
        end
      end else if (state != ST_IDLE && state != ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_128.sv
// Directed bench for aes_key_sched_128 using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched_128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic [127:0] val;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_sched_128 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [3:0] idx, output logic [127:0] v);
    rd_idx = idx;
    @(negedge clk);
    v = rd_key;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_kv", 128'(keys_valid), 128'(0));
    check("rst_rdkey", rd_key, 128'h0);
    check("rst_ready", 128'(key_ready), 128'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS key; key_valid stays high with a different key during EXPAND
    key_in    = FIPS_KEY;
    key_valid = 1'b1;
    @(negedge clk);
    key_in = 128'hffffffffffffffffffffffffffffffff;
    check("e0_busy", 128'(busy), 128'(1));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("exp_ready_%0d", k), 128'(key_ready), 128'(0));
      check($sformatf("exp_kv_%0d", k), 128'(keys_valid), 128'(0));
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("done_kv", 128'(keys_valid), 128'(1));
    check("done_busy", 128'(busy), 128'(0));
    check("done_ready", 128'(key_ready), 128'(1));

    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      @(negedge clk);
      check($sformatf("fips_rk%0d", i), rd_key, FIPS_RK[i]);
    end
    for (int i = 11; i <= 15; i++) begin
      rd_idx = 4'(i);
      @(negedge clk);
      check($sformatf("oor_idx%0d", i), rd_key, 128'h0);
    end
    check("still_done_kv", 128'(keys_valid), 128'(1));

    // Re-accept the zero key from DONE
    rd_idx    = 4'd5;
    key_in    = '0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("reacc_kv", 128'(keys_valid), 128'(0));
    check("reacc_old_rk5", rd_key, FIPS_RK[5]);
    @(negedge clk);
    check("cleared_rk5", rd_key, 128'h0);
    rd_idx = 4'd2;
    @(negedge clk);
    check("wr_rd_same_edge", rd_key, 128'h0);
    @(negedge clk);
    check("zero_rk2", rd_key, ZERO_RK2);
    repeat (6) @(negedge clk);
    check("zero_kv_e9", 128'(keys_valid), 128'(0));
    @(negedge clk);
    check("zero_kv_e10", 128'(keys_valid), 128'(1));
    rd(4'd0, val);  check("zero_rk0", val, 128'h0);
    rd(4'd1, val);  check("zero_rk1", val, ZERO_RK1);
    rd(4'd10, val); check("zero_rk10", val, ZERO_RK10);

    // Reset in the middle of an expansion
    rd_idx    = 4'd0;
    key_in    = FIPS_KEY;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 128'(busy), 128'(1));
    check("mid_rdkey", rd_key, FIPS_KEY);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_kv", 128'(keys_valid), 128'(0));
    check("arst_rdkey", rd_key, 128'h0);
    check("arst_ready", 128'(key_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 3; i++) begin
      rd(4'(i), val);
      check($sformatf("post_rst_rk%0d", i), val, 128'h0);
    end
    check("post_rst_ready", 128'(key_ready), 128'(1));
    check("post_rst_busy", 128'(busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_128.md
Name: aes_key_sched_128

Overview:
Sequential AES-128 key-schedule controller. It accepts a cipher key through a valid/ready handshake and iterates the combinational one-step expander once per cycle, with the correct Rcon each round. All 11 round keys (rk0..rk10) go into an internal register file. The cipher datapath downstream reads them through an indexed, registered read port.

Parameters:
CLEAR_ON_LOAD, 1, when 1 rk1..rk10 are zeroed on the key-accept edge; when 0 they keep stale values until overwritten.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  cipher key on key_in is valid
key_ready  output  1  block can accept a key; combinational, = (state != EXPAND)
key_in  input  128  cipher key, big-endian words w0=[127:96] .. w3=[31:0]
busy  output  1  registered; high while in EXPAND
keys_valid  output  1  registered; rk0..rk10 complete and consistent
rd_idx  input  4  round-key index 0..10
rd_key  output  128  registered read data; rk[rd_idx] sampled at the previous edge

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, rk0..rk10=0, cur=0, round=0, rcon=8'h01, busy=0, keys_valid=0, rd_key=0. key_ready=1 from reset.
- Mid-operation reset aborts the expansion and clears everything to the reset values.
- States: IDLE, EXPAND, DONE.
- Accept: key_valid && key_ready at an edge (E0), from IDLE or DONE. Effects at E0:
  - rk0<=key_in, cur<=key_in, round<=1, rcon<=8'h01.
  - keys_valid<=0, busy<=1, state<=EXPAND.
  - If CLEAR_ON_LOAD, rk1..rk10<=0.
- EXPAND: each edge Ek (k=1..10):
  - nxt = expand(cur, rcon); rk[round]<=nxt; cur<=nxt.
  - rcon<=xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 0); round<=round+1.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- At E10 (round==10): state<=DONE, busy<=0, keys_valid<=1.
  - Latency: keys_valid high 10 cycles after the accept edge; the schedule throughput is one key per 11 cycles.
- key_valid while in EXPAND is ignored (key_ready=0); no queuing.
- In DONE, a new accept is allowed: keys_valid drops at that same edge (no cycle with keys_valid=1 and mixed keys).
- IDLE with key_valid=0, or DONE: state holds, round keys unchanged.
- Read port, every edge in every state:
  - rd_key <= (rd_idx<=10) ? rk[rd_idx] : 128'h0; one-cycle latency.
  - During EXPAND, rd_key returns whatever is stored; consumers qualify with keys_valid.
- Write-then-read same index, same edge: rd_key returns the old value (register-before-write); the new value appears on the next edge.
- round and rcon never advance outside EXPAND; round wrap is impossible (exit at 10).
- key_ready is combinational from state only, never from key_valid (no combinational loop through the handshake).

Decomposition:
- Shared package aes_pkg: AES_NR=10; state encoding constants (IDLE/EXPAND/DONE); RCON_INIT=8'h01; xtime function; round-key index width (4).
- One sub-module: an instance of the existing aes_key_expand_128 (key_in=cur, rcon=rcon, key_out=nxt). No new sub-modules.
- FSM, counters, register file and read port live in aes_key_sched_128.

Test Plan:
- Reset then FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted -> keys_valid rises exactly 10 cycles later; rd_idx=1 gives a0fafe1788542cb123a339392a6c7605; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=0 returns the key.
- All-zero key -> rk1=62636363 repeated four times; rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid held high through EXPAND with a different key_in -> ignored; key_ready=0 for 10 cycles; results match the first key only.
- From DONE, accept the zero key -> keys_valid=0 at the accept edge; with CLEAR_ON_LOAD=1, rd_idx=5 reads 0 next cycle; after 10 cycles the zero-key results are correct.
- Assert rst_n=0 at cycle 4 of EXPAND -> busy=0, keys_valid=0, rd_key=0 asynchronously; rk1..rk3 read 0 after release; key_ready=1.
- rd_idx=11..15 -> rd_key=0; rd_idx sweep 0..10 in consecutive cycles -> each rk returned with exactly one cycle latency.
